// File: rtl/bsg_gateway_wh_link_arbiter.sv
// Wormhole link arbiter: picks one requester per packet by round-robin and keeps
// the shared link locked to it from header to last body flit, with zero-latency pass-through.
module bsg_gateway_wh_link_arbiter #(
    parameter int num_in_p     = 2,
    parameter int flit_width_p = 32,
    parameter int cord_width_p = 7,
    parameter int len_width_p  = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_in_p-1:0]              valid_i,
    input  logic [num_in_p*flit_width_p-1:0] data_i,
    output logic [num_in_p-1:0]              ready_and_o,
    output logic                             valid_o,
    output logic [flit_width_p-1:0]          data_o,
    input  logic                             ready_and_i,
    output logic [num_in_p-1:0]              grant_o
);
    localparam int sel_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;
    localparam logic [sel_width_lp-1:0] last_idx_lp = sel_width_lp'(num_in_p - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_WAIT = 2'd1,
        BODY     = 2'd2
    } state_e;

    state_e                  r_state;
    logic [sel_width_lp-1:0] r_sel;
    logic [sel_width_lp-1:0] r_rr_ptr;
    logic [len_width_p-1:0]  r_remaining;

    logic [sel_width_lp-1:0] w_scan;
    logic [sel_width_lp-1:0] w_rr_sel;
    logic                    w_rr_any;
    logic [sel_width_lp-1:0] w_cur_sel;
    logic                    w_cur_valid;
    logic [flit_width_p-1:0] w_cur_data;
    logic [len_width_p-1:0]  w_hdr_len;
    logic                    w_hs;

    function automatic logic [sel_width_lp-1:0] next_idx(input logic [sel_width_lp-1:0] p);
        if (p == last_idx_lp) begin
            return '0;
        end else begin
            return p + sel_width_lp'(1);
        end
    endfunction

    // Round-robin search: first valid requester at or above r_rr_ptr, wrapping to 0.
    always_comb begin
        w_scan   = r_rr_ptr;
        w_rr_sel = r_rr_ptr;
        w_rr_any = 1'b0;
        for (int i = 0; i < num_in_p; i++) begin
            w_rr_sel = (!w_rr_any && valid_i[w_scan]) ? w_scan : w_rr_sel;
            w_rr_any = w_rr_any | valid_i[w_scan];
            w_scan   = next_idx(w_scan);
        end
    end

    // Current owner: fresh arbitration in IDLE, latched owner otherwise.
    always_comb begin
        w_cur_sel = (r_state == IDLE) ? w_rr_sel : r_sel;
    end

    // Flit mux from the current owner's slice.
    always_comb begin
        w_cur_data = '0;
        for (int k = 0; k < num_in_p; k++) begin
            w_cur_data = (w_cur_sel == sel_width_lp'(k))
                       ? data_i[k*flit_width_p +: flit_width_p] : w_cur_data;
        end
    end

    // Owner's valid and header length field.
    always_comb begin
        w_cur_valid = valid_i[w_cur_sel];
        w_hdr_len   = w_cur_data[cord_width_p+len_width_p-1:cord_width_p];
    end

    // Link outputs; only the owner sees the downstream ready, everything off in reset.
    always_comb begin
        valid_o     = 1'b0;
        data_o      = w_cur_data;
        ready_and_o = '0;
        grant_o     = '0;
        if (reset_i) begin
            valid_o = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rr_any) begin
                        valid_o                = 1'b1;
                        ready_and_o[w_cur_sel] = ready_and_i;
                        grant_o[w_cur_sel]     = 1'b1;
                    end else begin
                        valid_o = 1'b0;
                    end
                end
                HDR_WAIT, BODY: begin
                    valid_o                = w_cur_valid;
                    ready_and_o[w_cur_sel] = ready_and_i;
                    grant_o[w_cur_sel]     = 1'b1;
                end
                default: begin
                    valid_o = 1'b0;
                end
            endcase
        end
    end

    // Link handshake strobe.
    always_comb begin
        w_hs = valid_o & ready_and_i;
    end

    // Packet FSM: ownership, round-robin pointer and body-flit countdown.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_rr_ptr    <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rr_any) begin
                        r_sel <= w_rr_sel;
                        if (ready_and_i) begin
                            r_rr_ptr <= next_idx(w_rr_sel);
                            if (w_hdr_len != '0) begin
                                r_remaining <= w_hdr_len;
                                r_state     <= BODY;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_state <= HDR_WAIT;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                HDR_WAIT: begin
                    // A withdrawn header releases the lock without advancing priority.
                    if (!w_cur_valid) begin
                        r_state <= IDLE;
                    end else if (ready_and_i) begin
                        r_rr_ptr <= next_idx(r_sel);
                        if (w_hdr_len != '0) begin
                            r_remaining <= w_hdr_len;
                            r_state     <= BODY;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_state <= HDR_WAIT;
                    end
                end
                BODY: begin
                    if (r_remaining == '0) begin
                        r_state <= IDLE;
                    end else if (w_hs) begin
                        r_remaining <= r_remaining - len_width_p'(1);
                        if (r_remaining == len_width_p'(1)) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= BODY;
                        end
                    end else begin
                        r_state <= BODY;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bsg_gateway_wh_link_arbiter.sv
// Directed bench: sources feed per-requester flit queues, the expected link order is
// queued as packets are scheduled and compared on every link handshake.
module tb_bsg_gateway_wh_link_arbiter;
    logic        clk = 1'b0;
    logic        reset_i;
    logic [1:0]  valid_i;
    logic [63:0] data_i;
    logic [1:0]  ready_and_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        ready_and_i;
    logic [1:0]  grant_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] exp_d[$];
    logic [1:0]  exp_g[$];
    logic [1:0]  src_en;

    always #5 clk = ~clk;

    bsg_gateway_wh_link_arbiter #(
        .num_in_p(2), .flit_width_p(32), .cord_width_p(7), .len_width_p(4)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
        .ready_and_o(ready_and_o), .valid_o(valid_o), .data_o(data_o),
        .ready_and_i(ready_and_i), .grant_o(grant_o)
    );

    function automatic logic [31:0] flit(input int req, input int pkt, input int idx, input int len);
        return {4'(req), 4'(pkt), 8'(idx), 5'd0, 4'(len), 7'(req)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Queue a packet at a source; the first nexp flits are expected on the link in call order.
    task automatic add_pkt(input int req, input int pkt, input int len, input int nexp);
        logic [31:0] f;
        for (int i = 0; i <= len; i++) begin
            f = flit(req, pkt, i, len);
            if (req == 0) q0.push_back(f);
            else          q1.push_back(f);
            if (i < nexp) begin
                exp_d.push_back(f);
                exp_g.push_back((req == 0) ? 2'b01 : 2'b10);
            end
        end
    endtask

    task automatic drive();
        valid_i[0]     = src_en[0] && (q0.size() > 0);
        valid_i[1]     = src_en[1] && (q1.size() > 0);
        data_i[31:0]   = (q0.size() > 0) ? q0[0] : 32'h0;
        data_i[63:32]  = (q1.size() > 0) ? q1[0] : 32'h0;
    endtask

    // One clock: score any link handshake, then retire accepted source flits.
    task automatic tick();
        logic [1:0]  hs;
        logic [31:0] ed;
        logic [1:0]  eg;
        @(negedge clk);
        if (!reset_i && valid_o && ready_and_i) begin
            if (exp_d.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_flit observed=%0h expected=none", data_o);
            end else begin
                ed = exp_d.pop_front();
                eg = exp_g.pop_front();
                chk("flit_data", data_o, ed);
                chk("flit_grant", grant_o, eg);
            end
        end
        chk("ready_within_grant", ready_and_o & ~grant_o, 2'b00);
        hs = valid_i & ready_and_o;
        @(posedge clk);
        #1;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        drive();
        #1;
    endtask

    initial begin
        reset_i     = 1'b1;
        ready_and_i = 1'b1;
        src_en      = 2'b11;
        valid_i     = 2'b00;
        data_i      = 64'h0;

        // Reset with a request pending: link must stay dark.
        add_pkt(1, 1, 0, 1);
        drive();
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset_valid", valid_o, 1'b0);
            chk("reset_grant", grant_o, 2'b00);
            chk("reset_ready", ready_and_o, 2'b00);
        end

        // Header-only packet on input 1 passes through the same cycle.
        reset_i = 1'b0;
        #1;
        chk("hdr_only_valid", valid_o, 1'b1);
        chk("hdr_only_grant", grant_o, 2'b10);
        chk("hdr_only_ready", ready_and_o, 2'b10);
        chk("hdr_only_data", data_o, flit(1, 1, 0, 0));
        tick();

        // rr_ptr wrapped to 0: input 0 wins next, state back in IDLE immediately.
        add_pkt(0, 2, 0, 1);
        add_pkt(1, 3, 0, 1);
        drive();
        #1;
        chk("rr_wrap_grant", grant_o, 2'b01);
        repeat (2) tick();
        chk("drain_1", exp_d.size(), 0);

        // Two len=3 packets each: whole packets alternate with no interleave.
        add_pkt(0, 4, 3, 4);
        add_pkt(1, 4, 3, 4);
        add_pkt(0, 5, 3, 4);
        add_pkt(1, 5, 3, 4);
        drive();
        repeat (4) tick();
        chk("alt_switch_grant", grant_o, 2'b10);
        repeat (12) tick();
        chk("drain_2", exp_d.size(), 0);

        // Header stalled 3 cycles while input 1 appears: lock holds on input 0.
        ready_and_i = 1'b0;
        add_pkt(0, 6, 1, 2);
        drive();
        #1;
        chk("hdr_stall_grant0", grant_o, 2'b01);
        chk("hdr_stall_valid", valid_o, 1'b1);
        tick();
        add_pkt(1, 7, 0, 1);
        drive();
        #1;
        chk("hdr_wait_grant1", grant_o, 2'b01);
        chk("hdr_wait_ready", ready_and_o, 2'b00);
        tick();
        chk("hdr_wait_grant2", grant_o, 2'b01);
        tick();
        ready_and_i = 1'b1;
        drive();
        #1;
        chk("hdr_accept_ready", ready_and_o, 2'b01);
        chk("hdr_accept_data", data_o, flit(0, 6, 0, 1));
        repeat (3) tick();
        chk("drain_3", exp_d.size(), 0);

        // Input 1 stalls in BODY with two flits left; input 0 must not slip in.
        add_pkt(1, 8, 3, 4);
        drive();
        repeat (2) tick();
        src_en = 2'b10 & 2'b00;
        src_en[0] = 1'b1;
        add_pkt(0, 9, 0, 1);
        drive();
        #1;
        repeat (2) begin
            chk("stall_valid", valid_o, 1'b0);
            chk("stall_grant", grant_o, 2'b10);
            chk("stall_ready0", ready_and_o[0], 1'b0);
            tick();
        end
        src_en = 2'b11;
        drive();
        repeat (3) tick();
        chk("drain_4", exp_d.size(), 0);

        // Reset in BODY (remaining=5, rr_ptr=1): everything returns to power-on state.
        add_pkt(0, 10, 5, 1);
        drive();
        tick();
        reset_i = 1'b1;
        drive();
        #1;
        chk("mid_reset_valid", valid_o, 1'b0);
        chk("mid_reset_grant", grant_o, 2'b00);
        tick();
        reset_i = 1'b0;
        q0.delete();
        drive();
        #1;
        chk("post_reset_idle_valid", valid_o, 1'b0);
        chk("post_reset_idle_grant", grant_o, 2'b00);
        add_pkt(0, 12, 0, 1);
        add_pkt(1, 11, 0, 1);
        drive();
        #1;
        chk("post_reset_prio", grant_o, 2'b01);
        repeat (2) tick();
        chk("drain_5", exp_d.size(), 0);

        // Maximum length: exactly 16 flits, then IDLE arbitrates input 0 at once.
        add_pkt(1, 13, 15, 16);
        drive();
        repeat (16) tick();
        add_pkt(0, 14, 0, 1);
        drive();
        #1;
        chk("max_len_idle_grant", grant_o, 2'b01);
        chk("max_len_idle_valid", valid_o, 1'b1);
        tick();
        chk("drain_6", exp_d.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
